// File: rtl/fp_int_pkg.sv
// Shared definitions for the fp_int_acc sequencer and its datapath.
//   EXP_W, MANT_W, ACC_W : term exponent, term mantissa and accumulator widths
//   seq_state_t          : sequencer control states
package fp_int_pkg;

    localparam int EXP_W  = 5;
    localparam int MANT_W = 14;
    localparam int ACC_W  = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SETTLE,
        WAIT,
        OUT
    } seq_state_t;

endpackage

// File: rtl/fp_int_acc_seq.sv
// Sequencer for the fp_int_acc alignment/accumulate datapath.
// Takes a stream of signed FP x INT product terms grouped into vectors by
// in_last, issues them one at a time to the external datapath, owns the running
// accumulator fed back to it, and presents one result per vector.
//   clk, rst          : clock, asynchronous active-low reset
//   cfg_exp_set       : alignment exponent, sampled on the first term of a vector
//   in_*              : term stream (valid/ready handshake)
//   dp_*  (outputs)   : registered term, vector exponent, accumulator, start strobe
//   dp_done/dp_result : datapath completion and new fixed-point sum
//   out_*             : per-vector result (valid/ready handshake)
module fp_int_acc_seq
    import fp_int_pkg::*;
#(
    parameter int TERM_CNT_W = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [EXP_W-1:0]      cfg_exp_set,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign,
    input  logic [EXP_W-1:0]      in_exp,
    input  logic [MANT_W-1:0]     in_mant,
    input  logic                  in_last,
    output logic                  dp_start,
    output logic                  dp_sign,
    output logic [EXP_W-1:0]      dp_exp,
    output logic [MANT_W-1:0]     dp_mant,
    output logic [EXP_W-1:0]      dp_exp_set,
    output logic [ACC_W-1:0]      dp_acc,
    input  logic                  dp_done,
    input  logic [ACC_W-1:0]      dp_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_acc,
    output logic [EXP_W-1:0]      out_exp,
    output logic [TERM_CNT_W-1:0] out_count,
    output logic                  out_err
);

    // Watchdog counts 0 .. TIMEOUT-1; the last value aborts the vector.
    localparam int                    WD_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WD_W-1:0]       WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [TERM_CNT_W-1:0] CNT_MAX = '1;

    seq_state_t            state_q, state_d;
    logic                  sign_q, sign_d;
    logic [EXP_W-1:0]      exp_q, exp_d;
    logic [MANT_W-1:0]     mant_q, mant_d;
    logic                  last_q, last_d;
    logic                  first_q, first_d;
    logic [EXP_W-1:0]      exp_set_q, exp_set_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [TERM_CNT_W-1:0] count_q, count_d;
    logic                  err_q, err_d;
    logic [WD_W-1:0]       wd_q, wd_d;

    // NOTE: every signal written here is given a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        mant_d    = mant_q;
        last_d    = last_q;
        first_d   = first_q;
        exp_set_d = exp_set_q;
        acc_d     = acc_q;
        count_d   = count_q;
        err_d     = err_q;
        wd_d      = wd_q;
        in_ready  = 1'b0;
        dp_start  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sign_d = in_sign;
                    exp_d  = in_exp;
                    mant_d = in_mant;
                    last_d = in_last;
                    if (first_q) begin
                        exp_set_d = cfg_exp_set;
                        acc_d     = '0;
                        count_d   = '0;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                dp_start = 1'b1;
                state_d  = SETTLE;
            end
            SETTLE: begin
                // dp_done may still show the previous term here; it is ignored.
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (dp_done) begin
                    acc_d = dp_result;
                    // Saturate the count and flag the overflow; keep accumulating.
                    if (count_q == CNT_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                    if (last_q) begin
                        state_d = OUT;
                    end else begin
                        first_d = 1'b0;
                        state_d = IDLE;
                    end
                end else if (wd_q == WD_LAST) begin
                    // Abort the vector: the accumulator keeps its pre-term value.
                    err_d   = 1'b1;
                    state_d = OUT;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    first_d = 1'b1;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of every other, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            mant_q    <= '0;
            last_q    <= 1'b0;
            first_q   <= 1'b1;
            exp_set_q <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            mant_q    <= mant_d;
            last_q    <= last_d;
            first_q   <= first_d;
            exp_set_q <= exp_set_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            err_q     <= err_d;
            wd_q      <= wd_d;
        end
    end

    assign dp_sign    = sign_q;
    assign dp_exp     = exp_q;
    assign dp_mant    = mant_q;
    assign dp_exp_set = exp_set_q;
    assign dp_acc     = acc_q;
    assign out_acc    = acc_q;
    assign out_exp    = exp_set_q;
    assign out_count  = count_q;
    assign out_err    = err_q;

endmodule

// File: tb/tb_fp_int_acc_seq.sv
// Self-checking bench for fp_int_acc_seq. A behavioural stand-in for the
// fp_int_acc datapath sits beside the sequencer (configurable latency, can be
// stuck); expected vector results come from a plain-arithmetic model of the
// term list, independent of the sequencer's internals.
module tb_fp_int_acc_seq;

    logic        clk;
    logic        rst;
    logic [4:0]  cfg_exp_set;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [4:0]  in_exp;
    logic [13:0] in_mant;
    logic        in_last;
    logic        dp_start;
    logic        dp_sign;
    logic [4:0]  dp_exp;
    logic [13:0] dp_mant;
    logic [4:0]  dp_exp_set;
    logic [31:0] dp_acc;
    logic        dp_done;
    logic [31:0] dp_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_acc;
    logic [4:0]  out_exp;
    logic [7:0]  out_count;
    logic        out_err;

    int checks   = 0;
    int failures = 0;

    fp_int_acc_seq #(.TERM_CNT_W(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .cfg_exp_set(cfg_exp_set),
        .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
        .in_exp(in_exp), .in_mant(in_mant), .in_last(in_last),
        .dp_start(dp_start), .dp_sign(dp_sign), .dp_exp(dp_exp),
        .dp_mant(dp_mant), .dp_exp_set(dp_exp_set), .dp_acc(dp_acc),
        .dp_done(dp_done), .dp_result(dp_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_exp(out_exp), .out_count(out_count), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Aligned magnitude of one term relative to the vector exponent.
    function automatic logic [31:0] term_val(input logic [4:0] e, input logic [13:0] m,
                                             input logic [4:0] es);
        logic [31:0] v;
        v = {18'b0, m};
        if (e >= es) return v << (e - es);
        else         return v >> (es - e);
    endfunction

    // Datapath stand-in: start clears done; done + result after dp_lat cycles.
    int          dp_lat   = 1;
    logic        dp_stuck = 1'b0;
    logic        dp_pend;
    int          dp_cnt;
    logic [31:0] dp_res_pend;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dp_done   <= 1'b0;
            dp_result <= '0;
            dp_pend   <= 1'b0;
            dp_cnt    <= 0;
        end else if (dp_start) begin
            dp_done     <= 1'b0;
            dp_pend     <= 1'b1;
            dp_cnt      <= dp_lat;
            dp_res_pend <= dp_sign ? dp_acc - term_val(dp_exp, dp_mant, dp_exp_set)
                                   : dp_acc + term_val(dp_exp, dp_mant, dp_exp_set);
        end else if (dp_pend && !dp_stuck) begin
            if (dp_cnt <= 1) begin
                dp_done   <= 1'b1;
                dp_result <= dp_res_pend;
                dp_pend   <= 1'b0;
            end else begin
                dp_cnt <= dp_cnt - 1;
            end
        end
    end

    typedef struct {
        logic        s;
        logic [4:0]  e;
        logic [13:0] m;
    } term_t;

    term_t cur_vec[$];

    function automatic logic [31:0] model_sum(input logic [4:0] es);
        logic [31:0] acc;
        acc = '0;
        foreach (cur_vec[i]) begin
            if (cur_vec[i].s) acc = acc - term_val(cur_vec[i].e, cur_vec[i].m, es);
            else              acc = acc + term_val(cur_vec[i].e, cur_vec[i].m, es);
        end
        return acc;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Present one term at a negedge, hold until accepted; returns at the
    // first negedge after the accepting edge with in_valid dropped.
    task automatic send_term(input logic s, input logic [4:0] e, input logic [13:0] m,
                             input logic last);
        int t;
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_last  = last;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("accept timeout", 32'(in_ready), 32'd1);
        else @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Send cur_vec as one vector; cfg_exp_set is scrambled after the first term.
    task automatic send_vec(input logic [4:0] es, input int gap);
        cfg_exp_set = es;
        foreach (cur_vec[i]) begin
            send_term(cur_vec[i].s, cur_vec[i].e, cur_vec[i].m, i == cur_vec.size() - 1);
            cfg_exp_set = ~es;
            if (i != cur_vec.size() - 1) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("out_valid timeout", 32'(out_valid), 32'd1);
    endtask

    // Check a result, hold it under backpressure for `hold` cycles while
    // offering a term that must not be taken, then consume it.
    task automatic check_out(input string nm, input logic [31:0] xa, input logic [4:0] xe,
                             input int xc, input logic xerr, input int hold, input int xn);
        int n;
        wait_out(n);
        if (xn >= 0) check({nm, " latency"}, 32'(n), 32'(xn));
        check({nm, " out_acc"},   out_acc,          xa);
        check({nm, " out_exp"},   32'(out_exp),     32'(xe));
        check({nm, " out_count"}, 32'(out_count),   32'(xc));
        check({nm, " out_err"},   32'(out_err),     32'(xerr));
        in_valid = 1'b1;
        in_sign  = 1'b1;
        in_exp   = 5'd1;
        in_mant  = 14'h3fff;
        in_last  = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({nm, " hold out_valid"}, 32'(out_valid), 32'd1);
            check({nm, " hold out_acc"},   out_acc,        xa);
            check({nm, " hold out_count"}, 32'(out_count), 32'(xc));
            check({nm, " hold in_ready"},  32'(in_ready),  32'd0);
            check({nm, " hold dp_start"},  32'(dp_start),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({nm, " released"}, 32'(out_valid), 32'd0);
    endtask

    typedef struct {
        logic [4:0]  es;
        int          n;
        logic        s  [4];
        logic [4:0]  e  [4];
        logic [13:0] m  [4];
        int          gap;
        int          hold;
        logic [31:0] x_acc;
        int          x_cnt;
    } vec_rec_t;

    vec_rec_t tbl[5];

    task automatic set_term(input int v, input int k, input logic s, input logic [4:0] e,
                            input logic [13:0] m);
        tbl[v].s[k] = s;
        tbl[v].e[k] = e;
        tbl[v].m[k] = m;
    endtask

    initial begin
        int          n;
        logic [4:0]  es;
        logic [31:0] xa;
        int          nt;

        #250_000;
        $display("FAIL global timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [4:0]  es;
        logic [31:0] xa;
        int          nt;

        // Table: exp_set, term count, gap, hold, expected acc/count.
        tbl[0].es = 5'd10; tbl[0].n = 1; tbl[0].gap = 0; tbl[0].hold = 10;
        set_term(0, 0, 1'b0, 5'd10, 14'd100);
        tbl[0].x_acc = 32'd100; tbl[0].x_cnt = 1;
        tbl[1].es = 5'd8; tbl[1].n = 3; tbl[1].gap = 0; tbl[1].hold = 0;
        set_term(1, 0, 1'b0, 5'd8, 14'd5);
        set_term(1, 1, 1'b0, 5'd10, 14'd3);
        set_term(1, 2, 1'b1, 5'd7, 14'd8);
        tbl[1].x_acc = 32'd13; tbl[1].x_cnt = 3;
        tbl[2].es = 5'd3; tbl[2].n = 2; tbl[2].gap = 4; tbl[2].hold = 1;
        set_term(2, 0, 1'b0, 5'd3, 14'd1);
        set_term(2, 1, 1'b0, 5'd3, 14'd2);
        tbl[2].x_acc = 32'd3; tbl[2].x_cnt = 2;
        tbl[3].es = 5'd0; tbl[3].n = 2; tbl[3].gap = 1; tbl[3].hold = 0;
        set_term(3, 0, 1'b0, 5'd31, 14'd1);
        set_term(3, 1, 1'b1, 5'd0, 14'd1);
        tbl[3].x_acc = 32'h7fff_ffff; tbl[3].x_cnt = 2;
        tbl[4].es = 5'd31; tbl[4].n = 2; tbl[4].gap = 0; tbl[4].hold = 2;
        set_term(4, 0, 1'b0, 5'd0, 14'd16383);
        set_term(4, 1, 1'b1, 5'd30, 14'd16383);
        tbl[4].x_acc = 32'hffff_e001; tbl[4].x_cnt = 2;

        rst         = 1'b0;
        cfg_exp_set = '0;
        in_valid    = 1'b0;
        in_sign     = 1'b0;
        in_exp      = '0;
        in_mant     = '0;
        in_last     = 1'b0;
        out_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_acc",   out_acc,        32'd0);
        check("reset out_count", 32'(out_count), 32'd0);
        check("reset out_err",   32'(out_err),   32'd0);
        check("reset dp_start",  32'(dp_start),  32'd0);
        check("reset in_ready",  32'(in_ready),  32'd1);
        rst = 1'b1;
        @(negedge clk);

        // Directed table vectors.
        for (int v = 0; v < 5; v++) begin
            cur_vec.delete();
            for (int k = 0; k < tbl[v].n; k++) cur_vec.push_back('{tbl[v].s[k], tbl[v].e[k], tbl[v].m[k]});
            send_vec(tbl[v].es, tbl[v].gap);
            check_out($sformatf("tbl%0d", v), tbl[v].x_acc, tbl[v].es, tbl[v].x_cnt,
                      1'b0, tbl[v].hold, 3);
        end

        // Watchdog: second term never completes; acc keeps the first term.
        cfg_exp_set = 5'd4;
        send_term(1'b0, 5'd4, 14'd50, 1'b0);
        send_term(1'b0, 5'd4, 14'd9, 1'b1);
        dp_stuck = 1'b1;
        check_out("wdog", 32'd50, 5'd4, 1, 1'b1, 2, 17);
        dp_stuck = 1'b0;

        // Reset during WAIT of the second term.
        cfg_exp_set = 5'd6;
        send_term(1'b0, 5'd6, 14'd20, 1'b0);
        dp_lat = 10;
        send_term(1'b0, 5'd6, 14'd30, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        check("midrst out_valid",  32'(out_valid),  32'd0);
        check("midrst out_acc",    out_acc,         32'd0);
        check("midrst out_count",  32'(out_count),  32'd0);
        check("midrst dp_exp_set", 32'(dp_exp_set), 32'd0);
        check("midrst dp_mant",    32'(dp_mant),    32'd0);
        check("midrst in_ready",   32'(in_ready),   32'd1);
        @(negedge clk);
        rst    = 1'b1;
        dp_lat = 1;
        @(negedge clk);
        cur_vec.delete();
        cur_vec.push_back('{1'b0, 5'd9, 14'd7});
        send_vec(5'd9, 0);
        check_out("postrst", 32'd7, 5'd9, 1, 1'b0, 0, 3);

        // Count boundary: 255 terms fit, 256 saturate and flag.
        for (int len = 255; len <= 256; len++) begin
            cur_vec.delete();
            for (int k = 0; k < len; k++) cur_vec.push_back('{1'b0, 5'd0, 14'd1});
            send_vec(5'd0, 0);
            check_out($sformatf("cnt%0d", len), 32'(len), 5'd0, 255, len == 256, 0, 3);
        end

        // Randomized vectors against the arithmetic model.
        for (int r = 0; r < 30; r++) begin
            es = 5'($urandom_range(0, 31));
            nt = $urandom_range(1, 5);
            cur_vec.delete();
            for (int k = 0; k < nt; k++)
                cur_vec.push_back('{1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                                    14'($urandom_range(0, 16383))});
            xa     = model_sum(es);
            dp_lat = $urandom_range(1, 5);
            send_vec(es, $urandom_range(0, 3));
            check_out($sformatf("rnd%0d", r), xa, es, nt, 1'b0, $urandom_range(0, 3), 2 + dp_lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_int_acc_seq.md
Name: fp_int_acc_seq

Overview:
- Sequencer for the fp_int_acc alignment/accumulate datapath.
- Accepts a stream of signed FP×INT product terms (sign, 5-bit exponent, 14-bit mantissa), grouped into vectors by `in_last`.
- Issues one term at a time to the datapath and owns the 32-bit running accumulator that is fed back as `fixed_point_acc`.
- Presents one aligned fixed-point result per vector on a valid/ready output.

Parameters:
- TERM_CNT_W, 8, width of per-vector term counter; max terms per vector = 2^TERM_CNT_W - 1.
- TIMEOUT, 15, max cycles spent in WAIT before the watchdog aborts.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- cfg_exp_set  input  5  alignment exponent; sampled on the first accepted term of each vector.
- in_valid  input  1  term valid.
- in_ready  output  1  term accepted when in_valid&&in_ready.
- in_sign  input  1  1 = subtract term.
- in_exp  input  5  term exponent.
- in_mant  input  14  term magnitude.
- in_last  input  1  last term of vector.
- dp_start  output  1  datapath start.
- dp_sign  output  1  registered term sign.
- dp_exp  output  5  registered term exponent.
- dp_mant  output  14  registered term mantissa.
- dp_exp_set  output  5  latched vector exponent.
- dp_acc  output  32  running accumulator fed to datapath.
- dp_done  input  1  datapath done.
- dp_result  input  32  datapath fixed-point sum.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer ready.
- out_acc  output  32  final accumulator.
- out_exp  output  5  exponent of out_acc (= latched exp_set).
- out_count  output  TERM_CNT_W  terms accumulated in vector.
- out_err  output  1  watchdog fired or term-count overflow in this vector.

Behaviour:
- Reset (rst=0, any time including mid-vector):
  - State → IDLE; all outputs, the accumulator, the counter and the error flag → 0.
  - The in-flight vector is discarded.
- States: IDLE, ISSUE, SETTLE, WAIT, OUT.
- IDLE:
  - in_ready=1.
  - On accept: register sign/exp/mant/last.
  - If this is the first term of a vector (first_q=1): latch cfg_exp_set into dp_exp_set, clear acc to 0, count=0.
  - → ISSUE.
- ISSUE: dp_start=1 for exactly one cycle; in_ready=0; → SETTLE.
- SETTLE:
  - dp_done is ignored this cycle, because the datapath clears its previous done here.
  - → WAIT; watchdog counter cleared.
- WAIT:
  - On dp_done=1: acc ← dp_result; count ← count+1.
    - If last_q → OUT.
    - Else → IDLE with first_q=0.
  - Watchdog increments each WAIT cycle. On reaching TIMEOUT: err ← 1, acc unchanged, → OUT (vector aborted).
- OUT:
  - out_valid=1; out_acc/out_exp/out_count/out_err are stable while out_valid&&!out_ready.
  - On out_ready=1: → IDLE with first_q=1; err cleared.
  - in_ready=0 while in OUT (no overlap of vectors).
- Throughput: fixed 3 cycles per term (ISSUE, SETTLE, WAIT with done) plus 1 IDLE accept cycle. Term accepted at edge N → its result lands in acc at edge N+3.
- Count overflow: a term that would make count wrap sets err=1. The count saturates at max, and accumulation continues.
- Arithmetic: the accumulator is a 32-bit wrapping two's-complement value. Controller performs no arithmetic beyond the counters; alignment and add/sub live in the datapath.
- A vector of one term (in_last on first term) is legal.
- in_valid low in IDLE mid-vector: wait indefinitely; acc is held.
- cfg_exp_set changes mid-vector are ignored.

Decomposition:
- Shared package fp_int_pkg:
  - width constants EXP_W=5, MANT_W=14, ACC_W=32.
  - state enum seq_state_t {IDLE, ISSUE, SETTLE, WAIT, OUT}.
- No sub-module needed. The fp_int_acc datapath is instantiated alongside by the integrator, not inside this block.
- Bench instantiates both blocks together.

Test Plan:
- Single-term vector with exp_set=10, term (+, exp 10, mant 100), in_last=1 → out_valid after 4 cycles with out_acc=100, out_exp=10, out_count=1, out_err=0.
- Three-term vector with exp_set=8: (+,8,5), (+,10,3), (-,7,8) → shift left 2 gives 12, shift right 1 gives 4; out_acc=5+12-4=13, out_count=3.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → outputs stable, in_ready=0, no term accepted. Release → next vector starts with acc=0 and a freshly sampled exp_set.
- Watchdog: tie dp_done=0 → after TIMEOUT=15 WAIT cycles, out_valid=1 with out_err=1 and out_acc = value before the stuck term.
- Reset mid-vector: deassert rst during WAIT of the 2nd term → all outputs 0 and state IDLE. The next vector (+,exp_set,7), last → out_acc=7, count=1.
- in_valid gaps: 4 idle cycles between terms of a 2-term vector (+,3,1),(+,3,2) with exp_set=3 → out_acc=3, out_count=2.
